// File: rtl/ysyx_23060025_wb_queue.sv
// Writeback queue: an in-order FIFO between the LSU and the GPR/CSR write
// ports. It absorbs write-port back-pressure, counts retired instructions and
// runs the ebreak drain/halt sequence.
//
// Handshake rules (both sides):
//   upstream   push   = lsu_valid_i & wbu_ready_o. wbu_ready_o depends only on
//              the registered fill level and FSM state, never on lsu_valid_i or
//              commit_ready_i. A producer seeing ready low holds its offer.
//   downstream commit = !empty & commit_ready_i. Write strobes and retire_o are
//              valid only in a commit cycle; the regfile/CSR file and this
//              queue both act on the same posedge.
module ysyx_23060025_wb_queue #(
   parameter int DATA_LEN = 32,
   parameter int REG_AW   = 5,
   parameter int DEPTH    = 4,
   parameter int CNT_W    = 64
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       lsu_valid_i,
   output logic                       wbu_ready_o,
   input  logic                       wd_i,
   input  logic [REG_AW-1:0]          wreg_i,
   input  logic [DATA_LEN-1:0]        reg_wdata_i,
   input  logic [2:0]                 csr_type_i,
   input  logic [11:0]                csr_waddr_i,
   input  logic [DATA_LEN-1:0]        csr_wdata_i,
   input  logic                       ebreak_flag_i,
   input  logic                       commit_ready_i,
   output logic                       wd_o,
   output logic [REG_AW-1:0]          wreg_o,
   output logic [DATA_LEN-1:0]        wdata_o,
   output logic [2:0]                 csr_type_o,
   output logic [11:0]                csr_waddr_o,
   output logic [DATA_LEN-1:0]        csr_wdata_o,
   output logic                       retire_o,
   output logic [CNT_W-1:0]           retire_cnt_o,
   output logic [$clog2(DEPTH):0]     occupancy_o,
   output logic                       halted_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] RET_ONE  = CNT_W'(1);

   // RUN accepts work; DRAIN lets queued entries (ending with the ebreak)
   // retire without taking new ones; HALT holds until reset.
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } wb_state_e;

   // Registered FSM state; the name is kept stable for external checkers.
   wb_state_e state_q;
   wb_state_e state_d;

   // Entry storage, one array per field.
   logic                wd_mem     [DEPTH];
   logic [REG_AW-1:0]   wreg_mem   [DEPTH];
   logic [DATA_LEN-1:0] wdata_mem  [DEPTH];
   logic [2:0]          csr_t_mem  [DEPTH];
   logic [11:0]         csr_a_mem  [DEPTH];
   logic [DATA_LEN-1:0] csr_d_mem  [DEPTH];
   logic                ebreak_mem [DEPTH];

   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W:0]   count_q;
   logic [CNT_W-1:0] retire_cnt_q;

   logic empty;
   logic full;
   logic push;
   logic pop;
   logic head_ebreak;

   assign empty       = (count_q == '0);
   assign full        = (count_q == FULL_CNT);
   assign wbu_ready_o = !full && (state_q == ST_RUN);
   assign push        = lsu_valid_i && wbu_ready_o;
   assign pop         = !empty && commit_ready_i;
   assign head_ebreak = !empty && ebreak_mem[rd_ptr_q];

   // Store the offered instruction in the tail slot on every accepted push.
   always_ff @(posedge clock) begin
      if (push) begin
         wd_mem[wr_ptr_q]     <= wd_i;
         wreg_mem[wr_ptr_q]   <= wreg_i;
         wdata_mem[wr_ptr_q]  <= reg_wdata_i;
         csr_t_mem[wr_ptr_q]  <= csr_type_i;
         csr_a_mem[wr_ptr_q]  <= csr_waddr_i;
         csr_d_mem[wr_ptr_q]  <= csr_wdata_i;
         ebreak_mem[wr_ptr_q] <= ebreak_flag_i;
      end
   end

   // Pointer and fill-level bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clock) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (push && !pop)      count_q <= count_q + CNT_ONE;
         else if (pop && !push) count_q <= count_q - CNT_ONE;
      end
   end

   // Retired-instruction counter, wrapping at its full width.
   always_ff @(posedge clock) begin
      if (!reset) begin
         retire_cnt_q <= '0;
      end else if (pop) begin
         retire_cnt_q <= retire_cnt_q + RET_ONE;
      end
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: an accepted ebreak starts the drain; its own commit halts.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN: begin
            if (push && ebreak_flag_i) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (pop && head_ebreak) state_d = ST_HALT;
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Head presentation: strobes are commit-qualified, data fields show the
   // head entry whenever one exists and read as zero on an empty queue.
   always_comb begin
      wd_o        = 1'b0;
      wreg_o      = '0;
      wdata_o     = '0;
      csr_type_o  = 3'd0;
      csr_waddr_o = 12'd0;
      csr_wdata_o = '0;
      if (!empty) begin
         wd_o        = pop && wd_mem[rd_ptr_q];
         wreg_o      = wreg_mem[rd_ptr_q];
         wdata_o     = wdata_mem[rd_ptr_q];
         csr_type_o  = {3{pop}} & csr_t_mem[rd_ptr_q];
         csr_waddr_o = csr_a_mem[rd_ptr_q];
         csr_wdata_o = csr_d_mem[rd_ptr_q];
      end
   end

   assign retire_o     = pop;
   assign retire_cnt_o = retire_cnt_q;
   assign occupancy_o  = count_q;
   assign halted_o     = (state_q == ST_HALT);

endmodule
